// File: rtl/switch_pkg.sv
// Shared defaults, output FSM state encoding and FIFO word layout
// for the switch ingress block.
package switch_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int PORT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2
   } state_e;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } fifo_word_t;

endpackage

// File: rtl/switch_ingress_if.sv
// Ingress/egress stream, switch request and error count bundle.
// slave: block side; master: upstream + switch core side.
interface switch_ingress_if #(
   parameter int DATA_W = switch_pkg::DATA_W,
   parameter int PORT_W = switch_pkg::PORT_W
);

   logic              in_valid;
   logic              in_sop;
   logic              in_eop;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              req;
   logic [PORT_W-1:0] dest;
   logic              grant;
   logic              out_valid;
   logic              out_sop;
   logic              out_eop;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [7:0]        err_cnt;

   modport slave (
      input  in_valid, in_sop, in_eop, in_data,
      input  grant, out_ready,
      output in_ready, req, dest,
      output out_valid, out_sop, out_eop, out_data,
      output err_cnt
   );

   modport master (
      output in_valid, in_sop, in_eop, in_data,
      output grant, out_ready,
      input  in_ready, req, dest,
      input  out_valid, out_sop, out_eop, out_data,
      input  err_cnt
   );

endinterface

// File: rtl/switch_ingress_fifo.sv
// Packet FIFO storing {sop, eop, data}; write, pop, rewind to the
// start of the packet being written, full/empty flags.
module switch_ingress_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_sop,
   input  logic              wr_eop,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   input  logic              rewind,
   output logic              full,
   output logic              empty,
   output logic              rd_sop,
   output logic              rd_eop,
   output logic [DATA_W-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] start_q, start_d;
   logic [AW:0] base;

   logic [DATA_W+1:0] mem [DEPTH];

   // A rewind and a write in the same cycle land the new word at
   // the old packet start (sop restarting a packet).
   always_comb begin
      base     = rewind ? start_q : wr_ptr_q;
      wr_ptr_d = base;
      start_d  = start_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         wr_ptr_d = base + ONE;
         if (wr_sop) start_d = base;
      end
      if (pop) rd_ptr_d = rd_ptr_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         start_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         start_q  <= start_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[base[AW-1:0]] <= {wr_sop, wr_eop, wr_data};
   end

   assign {rd_sop, rd_eop, rd_data} = mem[rd_ptr_q[AW-1:0]];

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/switch_ingress.sv
// Switch ingress: frames incoming packets into a FIFO, drops bad or
// oversize packets, requests the core and streams complete packets.
module switch_ingress #(
   parameter int DATA_W = switch_pkg::DATA_W,
   parameter int DEPTH  = switch_pkg::DEPTH,
   parameter int PORT_W = switch_pkg::PORT_W
) (
   input  logic            clk,
   input  logic            reset,
   switch_ingress_if.slave bus,
   input  logic            scan_in0,
   input  logic            scan_en,
   input  logic            test_mode,
   output logic            scan_out0
);

   import switch_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   state_e          state_q, state_d;
   logic            in_pkt_q, in_pkt_d;
   logic            drop_q, drop_d;
   logic            rdy_en_q, rdy_en_d;
   logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [7:0]      err_q, err_d;

   logic            wr_en, rewind, pop, acc;
   logic            pkt_inc, pkt_dec, err_inc;
   logic            full, empty, rd_sop, rd_eop;
   logic [DATA_W-1:0] rd_data;
   logic            unused_dft;

   switch_ingress_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_sop  (bus.in_sop),
      .wr_eop  (bus.in_eop),
      .wr_data (bus.in_data),
      .pop     (pop),
      .rewind  (rewind),
      .full    (full),
      .empty   (empty),
      .rd_sop  (rd_sop),
      .rd_eop  (rd_eop),
      .rd_data (rd_data)
   );

   // rdy_en_q holds in_ready low for the first cycle after reset.
   assign bus.in_ready = rdy_en_q && (drop_q || !full);
   assign acc          = bus.in_valid && bus.in_ready;
   assign pop          = (state_q == S_XFER) && bus.out_ready;
   assign pkt_dec      = pop && rd_eop;
   assign rdy_en_d     = 1'b1;

   always_comb begin
      wr_en    = 1'b0;
      rewind   = 1'b0;
      err_inc  = 1'b0;
      pkt_inc  = 1'b0;
      in_pkt_d = in_pkt_q;
      drop_d   = drop_q;
      if (drop_q) begin
         if (acc && bus.in_eop) begin
            drop_d  = 1'b0;
            err_inc = 1'b1;
         end
      end else if (full && in_pkt_q) begin
         // Packet cannot fit: discard what was stored of it.
         rewind   = 1'b1;
         drop_d   = 1'b1;
         in_pkt_d = 1'b0;
      end else if (acc) begin
         if (bus.in_sop) begin
            wr_en    = 1'b1;
            rewind   = in_pkt_q;
            err_inc  = in_pkt_q;
            in_pkt_d = !bus.in_eop;
            pkt_inc  = bus.in_eop;
         end else if (in_pkt_q) begin
            wr_en    = 1'b1;
            in_pkt_d = !bus.in_eop;
            pkt_inc  = bus.in_eop;
         end else begin
            err_inc = 1'b1;
         end
      end
   end

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      unique case ({pkt_inc, pkt_dec})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
         2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
      err_d = err_q;
      if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (pkt_cnt_q != '0 && !empty) state_d = S_REQ;
         S_REQ:  if (bus.grant) state_d = S_XFER;
         S_XFER: if (pkt_dec) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         in_pkt_q  <= 1'b0;
         drop_q    <= 1'b0;
         rdy_en_q  <= 1'b0;
         pkt_cnt_q <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         in_pkt_q  <= in_pkt_d;
         drop_q    <= drop_d;
         rdy_en_q  <= rdy_en_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_q     <= err_d;
      end
   end

   assign bus.req       = (state_q == S_REQ);
   assign bus.dest      = rd_data[PORT_W-1:0];
   assign bus.out_valid = (state_q == S_XFER);
   assign bus.out_sop   = rd_sop;
   assign bus.out_eop   = rd_eop;
   assign bus.out_data  = rd_data;
   assign bus.err_cnt   = err_q;

   assign unused_dft = ^{scan_in0, scan_en, test_mode};
   assign scan_out0  = 1'b0;

endmodule

// File: tb/tb_switch_ingress.sv
// Directed bench for switch_ingress: framing, back-pressure, grant
// delay, oversize drop and reset during transfer.
module tb_switch_ingress;

   import switch_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic scan_out0;

   always #5 clk = ~clk;

   switch_ingress_if #(.DATA_W(DATA_W), .PORT_W(PORT_W)) bus ();

   switch_ingress #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PORT_W (PORT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .scan_in0  (1'b0),
      .scan_en   (1'b0),
      .test_mode (1'b0),
      .scan_out0 (scan_out0)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int excl = 0;
   int req_cyc = 0;
   int ov_cyc = 0;
   int eop_cyc = 0;
   logic [PORT_W-1:0] req_dest = '0;
   logic req_p = 1'b0;
   logic ov_p = 1'b0;
   logic tog = 1'b0;
   fifo_word_t rx[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic fifo_word_t mk(input logic s, input logic e,
                                     input logic [DATA_W-1:0] d);
      fifo_word_t w;
      w.sop  = s;
      w.eop  = e;
      w.data = d;
      return w;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic s, input logic e,
                       input logic [DATA_W-1:0] d);
      int b;
      bus.in_valid = 1'b1;
      bus.in_sop   = s;
      bus.in_eop   = e;
      bus.in_data  = d;
      b = 0;
      while (!bus.in_ready && b < 100) begin
         tick();
         b++;
      end
      if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
      eop_cyc = cyc;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_rx(input string tag, input int n);
      int b;
      b = 0;
      while (rx.size() < n && b < 300) begin
         tick();
         b++;
      end
      check(tag, rx.size(), n);
   endtask

   task automatic wait_req();
      int b;
      b = 0;
      while (!bus.req && b < 100) begin
         tick();
         b++;
      end
      check("req_seen", bus.req, 1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (tog) bus.out_ready = ~bus.out_ready;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus.out_valid && bus.out_ready)
            rx.push_back(mk(bus.out_sop, bus.out_eop, bus.out_data));
         if (bus.req && bus.out_valid) excl++;
         if (bus.req && !req_p) begin
            req_cyc  = cyc;
            req_dest = bus.dest;
         end
         if (bus.out_valid && !ov_p) ov_cyc = cyc;
         req_p = bus.req;
         ov_p  = bus.out_valid;
      end
   end

   initial begin
      int bad;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sop    = 1'b0;
      bus.in_eop    = 1'b0;
      bus.in_data   = '0;
      bus.grant     = 1'b0;
      bus.out_ready = 1'b1;

      // reset state and release
      repeat (3) tick();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_req", bus.req, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_err", bus.err_cnt, 0);
      reset = 1'b1;
      check("rel_in_ready_lo", bus.in_ready, 0);
      tick();
      check("rel_in_ready_hi", bus.in_ready, 1);
      check("rel_req", bus.req, 0);
      check("scan_out0", scan_out0, 0);

      // single packet
      bus.grant = 1'b1;
      send(1'b1, 1'b0, 8'h02);
      send(1'b0, 1'b0, 8'hA5);
      send(1'b0, 1'b1, 8'h5A);
      wait_rx("single_cnt", 3);
      check("single_req_lat", req_cyc - eop_cyc, 2);
      check("single_dest", req_dest, 2);
      check("single_xfer_lat", ov_cyc - req_cyc, 1);
      check("single_w0", rx[0], mk(1'b1, 1'b0, 8'h02));
      check("single_w1", rx[1], mk(1'b0, 1'b0, 8'hA5));
      check("single_w2", rx[2], mk(1'b0, 1'b1, 8'h5A));
      check("single_err", bus.err_cnt, 0);
      rx.delete();

      // 16-word packet, back-pressure on the output
      bus.grant = 1'b0;
      for (int i = 0; i < 16; i++)
         send(i == 0, i == 15, 8'h30 + 8'(i));
      check("bp_full_ready", bus.in_ready, 0);
      tog = 1'b1;
      bus.grant = 1'b1;
      wait_rx("bp_cnt", 16);
      for (int i = 0; i < 16; i++)
         check("bp_word", rx[i],
               mk(i == 0, i == 15, 8'h30 + 8'(i)));
      check("bp_dest", req_dest, 0);
      tog = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      rx.delete();

      // grant held low for 20 cycles
      bus.grant = 1'b0;
      send(1'b1, 1'b0, 8'h01);
      send(1'b0, 1'b1, 8'h77);
      wait_req();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!bus.req || bus.dest != 2'd1 || bus.out_valid) bad++;
      end
      check("gdly_hold", bad, 0);
      bus.grant = 1'b1;
      tick();
      check("gdly_ov", bus.out_valid, 1);
      check("gdly_req", bus.req, 0);
      wait_rx("gdly_cnt", 2);
      check("gdly_w0", rx[0], mk(1'b1, 1'b0, 8'h01));
      check("gdly_w1", rx[1], mk(1'b0, 1'b1, 8'h77));
      rx.delete();

      // framing errors
      send(1'b0, 1'b0, 8'h99);
      send(1'b1, 1'b0, 8'h11);
      send(1'b1, 1'b1, 8'h22);
      wait_rx("frm_cnt", 1);
      repeat (10) tick();
      check("frm_cnt_final", rx.size(), 1);
      check("frm_w0", rx[0], mk(1'b1, 1'b1, 8'h22));
      check("frm_err", bus.err_cnt, 2);
      check("frm_dest", req_dest, 2);
      rx.delete();

      // oversize packet dropped, next packet intact
      for (int i = 0; i < 20; i++)
         send(i == 0, i == 19, 8'h40 + 8'(i));
      send(1'b1, 1'b0, 8'h03);
      send(1'b0, 1'b1, 8'hEE);
      wait_rx("ovs_cnt", 2);
      repeat (10) tick();
      check("ovs_cnt_final", rx.size(), 2);
      check("ovs_w0", rx[0], mk(1'b1, 1'b0, 8'h03));
      check("ovs_w1", rx[1], mk(1'b0, 1'b1, 8'hEE));
      check("ovs_err", bus.err_cnt, 3);
      check("ovs_dest", req_dest, 3);
      rx.delete();

      // reset after 2 of 5 words
      bus.out_ready = 1'b0;
      send(1'b1, 1'b0, 8'h05);
      send(1'b0, 1'b0, 8'hB1);
      send(1'b0, 1'b0, 8'hB2);
      send(1'b0, 1'b0, 8'hB3);
      send(1'b0, 1'b1, 8'hB4);
      bad = 0;
      while (!bus.out_valid && bad < 100) begin
         tick();
         bad++;
      end
      check("mid_xfer_ov", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
      check("mid_xfer_part", rx.size(), 2);
      reset = 1'b0;
      tick();
      tick();
      check("mid_rst_ov", bus.out_valid, 0);
      check("mid_rst_req", bus.req, 0);
      check("mid_rst_rdy", bus.in_ready, 0);
      check("mid_rst_err", bus.err_cnt, 0);
      reset = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      check("mid_rel_rdy", bus.in_ready, 1);
      check("mid_rel_ov", bus.out_valid, 0);
      check("mid_rel_req", bus.req, 0);
      rx.delete();
      send(1'b1, 1'b0, 8'h01);
      send(1'b0, 1'b1, 8'hC3);
      wait_rx("mid_new_cnt", 2);
      repeat (10) tick();
      check("mid_new_final", rx.size(), 2);
      check("mid_new_w0", rx[0], mk(1'b1, 1'b0, 8'h01));
      check("mid_new_w1", rx[1], mk(1'b0, 1'b1, 8'hC3));

      check("req_ov_excl", excl, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
